// File: rtl/spi_word_master.sv
// -----------------------------------------------------------------------------
// spi_word_master
//
// Bit-level SPI master (mode 0, CPOL=0, MSB first) sitting directly after the
// myo frame controller. Upstream hands over 16-bit words one at a time. Each
// word is shifted out on mosi while miso is shifted in, and every received
// word comes back with a one-cycle data_read_valid pulse. Back-to-back words
// stay inside a single slave-select window, so one motorboard frame is one
// ss_n low period. ss_n rises only after FRAME_GAP idle clocks.
//
// Handshake (upstream side): wren is a level request that qualifies Word.
// While the 1-deep holding register is free, the first cycle in which wren is
// seen high captures Word, and write_ack pulses high in the following cycle.
// After that, wren must fall before it can cause another capture. While the
// holding register is full, wren is ignored. A capture is allowed in the same
// cycle that the holding register moves into the shifter.
//
// Parameters:
//   HALF_PERIOD  clocks per sclk half-period (1..255)
//   SS_LEAD      clocks from ss_n low to shifter load; also the minimum ss_n
//                high time after a frame
//   FRAME_GAP    idle clocks after a word, with no word pending, before the
//                frame closes
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   Word, wren          transmit word and its level request
//   write_ack           pulse: Word captured into the holding register
//   di_req              level: frame open and holding register empty
//   data_read           last received word
//   data_read_valid     pulse: data_read updated
//   ss_n, sclk, mosi    SPI outputs
//   miso                SPI input
//   state_dbg           current FSM state (IDLE=0 LEAD=1 SHIFT=2 GAP=3 TRAIL=4)
//
// Build option:
//   SPI_LOOPBACK_EN     when defined, the receive shifter samples the internal
//                       mosi instead of the miso pin, so each received word
//                       equals the transmitted word.
// -----------------------------------------------------------------------------
module spi_word_master #(
  parameter int HALF_PERIOD = 25,
  parameter int SS_LEAD     = 4,
  parameter int FRAME_GAP   = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] Word,
  input  logic        wren,
  output logic        write_ack,
  output logic        di_req,
  output logic [15:0] data_read,
  output logic        data_read_valid,
  output logic        ss_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  localparam logic [7:0]  HALF_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [15:0] LEAD_LAST = 16'(SS_LEAD - 1);
  localparam logic [15:0] GAP_LAST  = 16'(FRAME_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] hold_word_q, hold_word_d;
  logic        hold_full_q, hold_full_d;
  logic        wren_used_q, wren_used_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [7:0]  half_cnt_q, half_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        write_ack_q, write_ack_d;
  logic [15:0] data_read_q, data_read_d;
  logic        valid_q, valid_d;

  logic        rx_in;
  logic        load;
  logic        capture;
  logic        capture_free;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = tx_q[15];
`else
  assign rx_in       = miso;
`endif

  always_comb begin
    state_d      = state_q;
    hold_word_d  = hold_word_q;
    hold_full_d  = hold_full_q;
    wren_used_d  = wren_used_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    half_cnt_d   = half_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    cnt_d        = cnt_q;
    sclk_d       = sclk_q;
    ss_n_d       = ss_n_q;
    write_ack_d  = 1'b0;
    data_read_d  = data_read_q;
    valid_d      = 1'b0;
    load         = 1'b0;
    capture      = 1'b0;
    // A capture that happens while the holding register is plainly empty.
    capture_free = wren && !wren_used_q && !hold_full_q;

    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        if (hold_full_q) begin
          state_d = LEAD;
          ss_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          load = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      SHIFT: begin
        if (bit_cnt_q == 6'd32) begin
          // One cycle after the 16th falling edge: publish the word and
          // either chain straight into the next one or start the idle gap.
          data_read_d = rx_q;
          valid_d     = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = '0;
          end
        end else if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          bit_cnt_d  = bit_cnt_q + 6'd1;
          if (!sclk_q) begin
            rx_d = {rx_q[14:0], rx_in};
          end else begin
            tx_d = {tx_q[14:0], 1'b0};
          end
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end

      GAP: begin
        if (hold_full_q) begin
          load = 1'b1;
        end else if (capture_free) begin
          // A word arriving now keeps the frame open even on the expiry
          // cycle; it is loaded on the next cycle.
          cnt_d = cnt_q;
        end else if (cnt_q == GAP_LAST) begin
          state_d = TRAIL;
          ss_n_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      TRAIL: begin
        ss_n_d = 1'b1;
        if (cnt_q == LEAD_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    if (load) begin
      state_d     = SHIFT;
      tx_d        = hold_word_q;
      rx_d        = '0;
      hold_full_d = 1'b0;
      half_cnt_d  = '0;
      bit_cnt_d   = '0;
      sclk_d      = 1'b0;
    end

    // The holding register may be refilled in the very cycle it is drained.
    capture = wren && !wren_used_q && (!hold_full_q || load);
    if (capture) begin
      hold_word_d = Word;
      hold_full_d = 1'b1;
      write_ack_d = 1'b1;
      wren_used_d = 1'b1;
    end
    if (!wren) begin
      wren_used_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_word_q <= '0;
      hold_full_q <= 1'b0;
      wren_used_q <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      half_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      write_ack_q <= 1'b0;
      data_read_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_full_q <= hold_full_d;
      wren_used_q <= wren_used_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      half_cnt_q  <= half_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      write_ack_q <= write_ack_d;
      data_read_q <= data_read_d;
      valid_q     <= valid_d;
    end
  end

  // mosi always shows the head of the transmit shifter; it is 0 when idle
  // because the shifter is empty after 16 shifts and after reset.
  assign mosi            = tx_q[15];
  assign sclk            = sclk_q;
  assign ss_n            = ss_n_q;
  assign write_ack       = write_ack_q;
  assign data_read       = data_read_q;
  assign data_read_valid = valid_q;
  assign di_req          = !ss_n_q && !hold_full_q;
  assign state_dbg       = state_q;

endmodule
